// File: rtl/bcd_tally.sv
// Two-digit BCD up/down tally driven by two debounced active-low pushbuttons,
// with a synchronous clamped load and a one-cycle wrap pulse.
module bcd_tally #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_inc_n,
    input  logic       key_dec_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       wrap
);

    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the increment key, index 1 the decrement key.
    logic [1:0]  raw_n;
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  accepted;
    logic [1:0]  accepted_d;
    logic [1:0]  press;
    logic [15:0] db_cnt [2];

    assign raw_n = {key_dec_n, key_inc_n};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            accepted   <= 2'b11;
            accepted_d <= 2'b11;
            press      <= 2'b00;
            db_cnt[0]  <= '0;
            db_cnt[1]  <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                sync1[k] <= raw_n[k];
                sync2[k] <= sync1[k];
                if (sync2[k] == accepted[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == CNT_MAX) begin
                    accepted[k] <= sync2[k];
                    db_cnt[k]   <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 16'd1;
                end
                accepted_d[k] <= accepted[k];
                // Falling edge of the accepted level only; release is silent.
                press[k] <= accepted_d[k] & ~accepted[k];
            end
        end
    end

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    logic inc_ev;
    logic dec_ev;

    assign inc_ev = press[0] & ~press[1];
    assign dec_ev = press[1] & ~press[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            ones <= 4'd0;
            tens <= 4'd0;
            wrap <= 1'b0;
        end else if (load) begin
            ones <= clamp9(load_val[3:0]);
            tens <= clamp9(load_val[7:4]);
            wrap <= 1'b0;
        end else if (inc_ev) begin
            wrap <= 1'b0;
            if (ones == 4'd9) begin
                ones <= 4'd0;
                if (tens == 4'd9) begin
                    tens <= 4'd0;
                    wrap <= 1'b1;
                end else begin
                    tens <= tens + 4'd1;
                end
            end else begin
                ones <= ones + 4'd1;
            end
        end else if (dec_ev) begin
            wrap <= 1'b0;
            if (ones == 4'd0) begin
                ones <= 4'd9;
                if (tens == 4'd0) begin
                    tens <= 4'd9;
                    wrap <= 1'b1;
                end else begin
                    tens <= tens - 4'd1;
                end
            end else begin
                ones <= ones - 4'd1;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_tally.sv
// Bench for bcd_tally: directed scenarios plus random key/load episodes
// checked against an integer 0..99 model of the tally.
module tb_bcd_tally;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic       key_inc_n;
    logic       key_dec_n;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       wrap;

    int n_assert = 0;
    int n_fail   = 0;
    int wrap_cnt = 0;
    int model    = 0;
    int model_wraps = 0;

    bcd_tally #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk),
        .reset(reset),
        .key_inc_n(key_inc_n),
        .key_dec_n(key_dec_n),
        .load(load),
        .load_val(load_val),
        .ones(ones),
        .tens(tens),
        .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (wrap === 1'b1) wrap_cnt++;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_load(input logic [7:0] v);
        int t, o;
        t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        o = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return t * 10 + o;
    endfunction

    // Clean press of the selected keys, held well past debounce, then a clean release.
    task automatic press(input bit inc, input bit dec);
        if (inc) key_inc_n = 1'b0;
        if (dec) key_dec_n = 1'b0;
        cycles(12);
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        cycles(12);
    endtask

    task automatic model_step(input bit inc, input bit dec);
        if (inc && !dec) begin
            if (model == 99) model_wraps++;
            model = (model + 1) % 100;
        end else if (dec && !inc) begin
            if (model == 0) model_wraps++;
            model = (model + 99) % 100;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        cycles(1);
        load = 1'b0;
        cycles(1);
        model = clamp_load(v);
    endtask

    initial begin
        int w0;
        reset = 1'b1;
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        load = 1'b0;
        load_val = 8'h00;
        cycles(3);
        chk("reset_count", {tens, ones}, 8'h00);
        chk("reset_wrap", {7'd0, wrap}, 8'h00);
        reset = 1'b0;
        cycles(2);

        // Clean increment press: first change exactly 7 edges after first sample.
        w0 = wrap_cnt;
        key_inc_n = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cycles(1);
            chk($sformatf("latency_e%0d", k), {tens, ones}, (k >= 7) ? 8'h01 : 8'h00);
        end
        key_inc_n = 1'b1;
        cycles(12);
        chk("latency_final", {tens, ones}, 8'h01);
        chk("latency_nowrap", 8'(wrap_cnt - w0), 8'h00);
        model = 1;

        // Bounce of 3 cycles low / 3 high never reaches the debounce threshold.
        do_load(8'h00);
        for (int i = 0; i < 5; i++) begin
            key_inc_n = 1'b0;
            cycles(3);
            key_inc_n = 1'b1;
            cycles(3);
        end
        cycles(12);
        chk("bounce_count", {tens, ones}, 8'h00);

        // Wrap in both directions.
        do_load(8'h99);
        chk("load_99", {tens, ones}, 8'h99);
        w0 = wrap_cnt;
        press(1, 0);
        chk("wrap_up_count", {tens, ones}, 8'h00);
        chk("wrap_up_pulse", 8'(wrap_cnt - w0), 8'h01);
        w0 = wrap_cnt;
        press(0, 1);
        chk("wrap_dn_count", {tens, ones}, 8'h99);
        chk("wrap_dn_pulse", 8'(wrap_cnt - w0), 8'h01);

        // Simultaneous presses cancel.
        do_load(8'h42);
        w0 = wrap_cnt;
        press(1, 1);
        chk("both_count", {tens, ones}, 8'h42);
        chk("both_wrap", 8'(wrap_cnt - w0), 8'h00);

        // Load held through a press discards it; nibble clamping.
        load = 1'b1;
        load_val = 8'hC7;
        press(1, 0);
        load = 1'b0;
        cycles(2);
        chk("load_over_press", {tens, ones}, 8'h97);
        do_load(8'h3F);
        chk("load_clamp_3f", {tens, ones}, 8'h39);
        do_load(8'hFF);
        chk("load_clamp_ff", {tens, ones}, 8'h99);

        // Reset mid-debounce, key kept low: re-debounced to a single decrement.
        do_load(8'h57);
        key_dec_n = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        chk("rst_mid_count", {tens, ones}, 8'h00);
        chk("rst_mid_wrap", {7'd0, wrap}, 8'h00);
        w0 = wrap_cnt;
        cycles(30);
        chk("rst_redebounce", {tens, ones}, 8'h99);
        chk("rst_redebounce_wrap", 8'(wrap_cnt - w0), 8'h01);
        key_dec_n = 1'b1;
        cycles(12);
        model = 99;

        // Random episodes against the integer model.
        model_wraps = 0;
        w0 = wrap_cnt;
        for (int ep = 0; ep < 60; ep++) begin
            int op;
            op = $urandom_range(0, 5);
            case (op)
                0, 1: begin press(1, 0); model_step(1, 0); end
                2, 3: begin press(0, 1); model_step(0, 1); end
                4: begin
                    if ($urandom_range(0, 1) == 1) begin
                        press(1, 1);
                    end else begin
                        bit use_inc;
                        use_inc = ($urandom_range(0, 1) == 1);
                        for (int b = 0; b < int'($urandom_range(2, 5)); b++) begin
                            if (use_inc) key_inc_n = 1'b0; else key_dec_n = 1'b0;
                            cycles($urandom_range(1, D - 1));
                            key_inc_n = 1'b1;
                            key_dec_n = 1'b1;
                            cycles($urandom_range(1, 3));
                        end
                        cycles(12);
                    end
                end
                default: do_load(8'($urandom_range(0, 255)));
            endcase
            chk($sformatf("rand_ep%0d", ep), {tens, ones}, to_bcd(model));
        end
        chk("rand_wraps", 8'(wrap_cnt - w0), 8'(model_wraps));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
